fir_axil_regs: RTL and testbench
================================

// Module: fir_axil_regs
// PURPOSE
//   AXI4-Lite responder holding the stereo FIR control register and coefficient shadow.
//   Accepts host writes and reads: CTRL at 0x00, STATUS at 0x04, NTAPS at 0x08,
//   and coefficients h[i] at 0x10+4*i.
//   Drives the enable level, the clear-state pulse and the coefficient write port into the FIR core.
// PARAMETERS
//   C_S_AXI_DATA_WIDTH  32  AXI-Lite data width (fixed at 32)
//   C_S_AXI_ADDR_WIDTH  10  AXI-Lite address width
//   FIR_NTAPS           16  number of coefficients, 1..(2^(ADDR_WIDTH-2))-4
//   COEFF_WIDTH         16  coefficient width, Q1.15 signed, occupies wdata[15:0]
// PORTS
//   aclk           in   1       system clock
//   aresetn        in   1       async active-low reset
//   s_axi_awaddr   in   AW      write address
//   s_axi_awvalid  in   1       write address valid
//   s_axi_awready  out  1       write address ready
//   s_axi_wdata    in   32      write data
//   s_axi_wstrb    in   4       byte strobes
//   s_axi_wvalid   in   1       write data valid
//   s_axi_wready   out  1       write data ready
//   s_axi_bresp    out  2       00 OKAY, 10 SLVERR
//   s_axi_bvalid   out  1       write response valid
//   s_axi_bready   in   1       write response ready
//   s_axi_araddr   in   AW      read address
//   s_axi_arvalid  in   1       read address valid
//   s_axi_arready  out  1       read address ready
//   s_axi_rdata    out  32      read data
//   s_axi_rresp    out  2       read response
//   s_axi_rvalid   out  1       read data valid
//   s_axi_rready   in   1       read data ready
//   fir_enable     out  1       CTRL[0] level
//   fir_clear      out  1       one-cycle clear-state pulse
//   coeff_we       out  1       coefficient write strobe, one cycle
//   coeff_addr     out  $clog2(FIR_NTAPS)  tap index
//   coeff_wdata    out  COEFF_WIDTH        coefficient value
// BEHAVIOUR
//   Reset (async, aresetn=0): all outputs 0, including all readies. All regs and the shadow are cleared.
//     On the first aclk edge after release: awready=wready=arready=1.
//   Address decode: addr[AW-1:2] only; addr[1:0] are ignored.
//     Coefficient index = (addr-0x10)>>2; it is valid only if it is < FIR_NTAPS.
//   Write FSM, W_IDLE/W_RESP:
//     - In W_IDLE, AW and W are accepted independently, each in any order or in the same cycle.
//     - Each accepted channel is latched and its ready is dropped until the response completes.
//     - When both are latched, commit the write and enter W_RESP the next cycle with bvalid=1.
//     - bvalid and bresp are held until bready; then return to W_IDLE with awready=wready=1 the next cycle.
//     - Minimum write throughput: one write per 3 cycles.
//   Write effects, applied on the commit cycle:
//     - CTRL: bit0 is stored as fir_enable when wstrb[0]=1.
//       If bit1=1 and wstrb[0]=1, fir_clear pulses for exactly one cycle, one cycle after commit.
//       bit1 always reads back 0.
//     - Coefficient: shadow[idx] bytes are updated per wstrb[1:0]; wstrb[3:2] and wdata[31:16] are ignored.
//       coeff_we pulses for one cycle, one cycle after commit, carrying coeff_addr=idx and the merged value.
//       Coefficient writes are legal while fir_enable=1.
//     - STATUS, NTAPS, 0x0C and out-of-range addresses: no state change, bresp=SLVERR.
//   Read FSM, R_IDLE/R_DATA:
//     - arready=1 in R_IDLE; the address is latched on arvalid.
//     - Next cycle: rvalid=1 with registered rdata and rresp, held stable until rready, then R_IDLE.
//     - CTRL returns {30'b0,0,enable}. STATUS returns {31'b0,enable}. NTAPS returns FIR_NTAPS.
//     - Coefficients return sign-extended to 32 bits.
//     - Unmapped addresses return rdata=0 with SLVERR.
//   Simultaneous read and write to the same coefficient in the same cycle:
//     the read returns the pre-write value.
//     The read and write channels are fully independent.
//   Reset mid-transaction: bvalid/rvalid drop immediately.
//     Pending latched AW/W are discarded and no coeff_we or fir_clear is issued.
// CONFIGURATION
//   FIR_REGS_COEFF_READBACK_EN defined: the full shadow array is kept and coefficient reads return the stored value.
//   FIR_REGS_COEFF_READBACK_EN undefined: no shadow array is kept.
//     Coefficient reads return 0 with OKAY.
//     A partial-strobe write merges with 0 rather than with the old value.
//     coeff_we behaviour is unchanged.
// TESTING
//   1. Reset then idle -> all outputs 0 in reset; awready=wready=arready=1 one cycle after aresetn rises.
//   2. Write 0x00=0x2 -> bresp=OKAY, fir_clear high exactly 1 cycle, fir_enable=0; read 0x00 returns 0x0.
//   3. Write 0x10=0x7FFF, 0x14=0x4000 -> coeff_we pulses with (0,0x7FFF) then (1,0x4000).
//      With READBACK_EN, a read of 0x14 returns 0x00004000.
//   4. AW presented 3 cycles before W, and bready held low for 5 cycles
//      -> one commit, bvalid stable for 5 cycles, no second write.
//   5. Write 0x10+4*FIR_NTAPS and read 0x3FC -> SLVERR on both, rdata=0, coeff_we never asserted.
//   6. Write 0x10=0xFFFF8000 then read 0x10 (READBACK_EN) -> 0xFFFF8000.
//      Write with wstrb=0x1, data 0x12 -> shadow=0x8012.

Source files
------------

// File: rtl/fir_axil_regs.sv
// AXI4-Lite register block for the stereo FIR: CTRL, STATUS, NTAPS and the coefficient write port.
// Define FIR_REGS_COEFF_READBACK_EN to keep a coefficient shadow that the host can read back.
module fir_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 10,
  parameter int unsigned FIR_NTAPS          = 16,
  parameter int unsigned COEFF_WIDTH        = 16
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 s_axi_awaddr,
  input  logic                                          s_axi_awvalid,
  output logic                                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                 s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               s_axi_wstrb,
  input  logic                                          s_axi_wvalid,
  output logic                                          s_axi_wready,
  output logic [1:0]                                    s_axi_bresp,
  output logic                                          s_axi_bvalid,
  input  logic                                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 s_axi_araddr,
  input  logic                                          s_axi_arvalid,
  output logic                                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                 s_axi_rdata,
  output logic [1:0]                                    s_axi_rresp,
  output logic                                          s_axi_rvalid,
  input  logic                                          s_axi_rready,
  output logic                                          fir_enable,
  output logic                                          fir_clear,
  output logic                                          coeff_we,
  output logic [(FIR_NTAPS > 1 ? $clog2(FIR_NTAPS) : 1)-1:0] coeff_addr,
  output logic [COEFF_WIDTH-1:0]                        coeff_wdata
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned WORD_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned IDX_W   = (FIR_NTAPS > 1) ? $clog2(FIR_NTAPS) : 1;
  localparam int unsigned STRB_W  = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned STRB_US = 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e                 w_state_q;
  r_state_e                 r_state_q;
  logic                     awready_q, wready_q, aw_got_q, w_got_q;
  logic [WORD_W-1:0]        aw_word_q;
  logic [COEFF_WIDTH-1:0]   wdata_q;
  logic [STRB_US-1:0]       wstrb_q;
  logic                     bvalid_q;
  logic [1:0]               bresp_q;
  logic                     arready_q, rvalid_q;
  logic [DW-1:0]            rdata_q;
  logic [1:0]               rresp_q;
  logic                     enable_q, clear_q, coeff_we_q;
  logic [IDX_W-1:0]         coeff_addr_q;
  logic [COEFF_WIDTH-1:0]   coeff_wdata_q;

  logic                     wr_commit_c, wr_is_ctrl_c, wr_is_coeff_c;
  logic [WORD_W-1:0]        wr_cidx_c, ar_word_c, rd_cidx_c;
  logic [IDX_W-1:0]         wr_idx_c;
  logic [COEFF_WIDTH-1:0]   coeff_old_c, coeff_mask_c, coeff_merged_c;
  logic [DW-1:0]            rd_data_c;
  logic [1:0]               rd_resp_c;

  // Write-side decode and byte merge of the latched beat
  always_comb begin
    wr_commit_c    = (w_state_q == W_IDLE) && aw_got_q && w_got_q;
    wr_cidx_c      = aw_word_q - WORD_W'(4);
    wr_idx_c       = IDX_W'(wr_cidx_c);
    wr_is_ctrl_c   = (aw_word_q == '0);
    wr_is_coeff_c  = (aw_word_q >= WORD_W'(4)) && (wr_cidx_c < WORD_W'(FIR_NTAPS));
    coeff_mask_c   = COEFF_WIDTH'({{8{wstrb_q[1]}}, {8{wstrb_q[0]}}});
    coeff_merged_c = (wdata_q & coeff_mask_c) | (coeff_old_c & ~coeff_mask_c);
  end

`ifdef FIR_REGS_COEFF_READBACK_EN
  logic [COEFF_WIDTH-1:0] shadow_q [FIR_NTAPS];
  logic [IDX_W-1:0]       rd_idx_c;

  assign coeff_old_c = shadow_q[wr_idx_c];
  assign rd_idx_c    = IDX_W'(rd_cidx_c);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(FIR_NTAPS); i++) shadow_q[i] <= '0;
    end else if (wr_commit_c && wr_is_coeff_c) begin
      shadow_q[wr_idx_c] <= coeff_merged_c;
    end
  end
`else
  // Without a shadow, partial-strobe writes merge against zero
  assign coeff_old_c = '0;
`endif

  // Read-side decode straight off the AR channel; captured on the handshake
  always_comb begin
    ar_word_c = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    rd_cidx_c = ar_word_c - WORD_W'(4);
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    if (ar_word_c == WORD_W'(0)) begin
      rd_data_c = DW'(enable_q);
    end else if (ar_word_c == WORD_W'(1)) begin
      rd_data_c = DW'(enable_q);
    end else if (ar_word_c == WORD_W'(2)) begin
      rd_data_c = DW'(FIR_NTAPS);
    end else if ((ar_word_c >= WORD_W'(4)) && (rd_cidx_c < WORD_W'(FIR_NTAPS))) begin
`ifdef FIR_REGS_COEFF_READBACK_EN
      rd_data_c = DW'($signed(shadow_q[rd_idx_c]));
`endif
    end else begin
      rd_resp_c = RESP_SLVERR;
    end
  end

  // Write FSM: latch AW and W independently, commit once both are held
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q     <= W_IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      aw_got_q      <= 1'b0;
      w_got_q       <= 1'b0;
      aw_word_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      enable_q      <= 1'b0;
      clear_q       <= 1'b0;
      coeff_we_q    <= 1'b0;
      coeff_addr_q  <= '0;
      coeff_wdata_q <= '0;
    end else begin
      clear_q    <= 1'b0;
      coeff_we_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (s_axi_awvalid && awready_q) begin
            aw_word_q <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            aw_got_q  <= 1'b1;
            awready_q <= 1'b0;
          end else if (!aw_got_q) begin
            awready_q <= 1'b1;
          end
          if (s_axi_wvalid && wready_q) begin
            wdata_q  <= s_axi_wdata[COEFF_WIDTH-1:0];
            wstrb_q  <= s_axi_wstrb[STRB_US-1:0];
            w_got_q  <= 1'b1;
            wready_q <= 1'b0;
          end else if (!w_got_q) begin
            wready_q <= 1'b1;
          end
          if (wr_commit_c) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= RESP_SLVERR;
            if (wr_is_ctrl_c) begin
              bresp_q <= RESP_OKAY;
              if (wstrb_q[0]) begin
                enable_q <= wdata_q[0];
                clear_q  <= wdata_q[1];
              end
            end else if (wr_is_coeff_c) begin
              bresp_q       <= RESP_OKAY;
              coeff_we_q    <= 1'b1;
              coeff_addr_q  <= wr_idx_c;
              coeff_wdata_q <= coeff_merged_c;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: one outstanding read, data held until rready
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            r_state_q <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data_c;
            rresp_q   <= rd_resp_c;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign fir_enable    = enable_q;
  assign fir_clear     = clear_q;
  assign coeff_we      = coeff_we_q;
  assign coeff_addr    = coeff_addr_q;
  assign coeff_wdata   = coeff_wdata_q;

  // Sub-word address bits, upper data lanes and upper strobes carry no meaning here
  logic unused_c;
  assign unused_c = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                      s_axi_wdata[DW-1:COEFF_WIDTH], s_axi_wstrb[STRB_W-1:STRB_US]};

endmodule

// File: tb/tb_fir_axil_regs.sv
// Self-checking bench for fir_axil_regs: vector table plus multi-cycle corner sequences.
// Expected coefficient readback follows FIR_REGS_COEFF_READBACK_EN.
module tb_fir_axil_regs;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 4;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;
`ifdef FIR_REGS_COEFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic          fir_enable, fir_clear, coeff_we;
  logic [IW-1:0] coeff_addr;
  logic [CW-1:0] coeff_wdata;

  fir_axil_regs #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .FIR_NTAPS(NT), .COEFF_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .fir_enable(fir_enable), .fir_clear(fir_clear), .coeff_we(coeff_we),
    .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  bit clr_prev = 1'b0;

  typedef struct { logic [IW-1:0] idx; logic [CW-1:0] val; } we_t;
  we_t exp_q[$];
  we_t mon_e;

  typedef struct {
    bit rd; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] strb;
    logic [1:0] resp; logic [31:0] rdata; bit we; logic [IW-1:0] idx; logic [CW-1:0] val;
    bit clr; bit en;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Coefficient-port scoreboard and clear-pulse monitor
  always @(negedge aclk) begin
    if (aresetn) begin
      if (fir_clear) begin
        clr_cnt++;
        if (clr_prev) begin
          checks++; errors++;
          $display("FAIL fir_clear pulse: got 2+ cycles expected 1");
        end
      end
      clr_prev = fir_clear;
      if (coeff_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL coeff_we unexpected: got idx=%0d val=0x%04h expected none", coeff_addr, coeff_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("coeff_addr", 64'(coeff_addr), 64'(mon_e.idx));
          chk("coeff_wdata", 64'(coeff_wdata), 64'(mon_e.val));
        end
      end
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lag, input int b_lag, output logic [1:0] resp);
    bit aw_pend, w_pend, aw_fire, w_fire;
    int cyc;
    aw_pend = 1'b1; w_pend = 1'b1; cyc = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = (w_lag == 0);
    while ((aw_pend || w_pend) && cyc < 40) begin
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(negedge aclk); cyc++;
      if (aw_fire) begin s_axi_awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin s_axi_wvalid = 1'b0;  w_pend = 1'b0;  end
      if (w_pend && !s_axi_wvalid && cyc >= w_lag) s_axi_wvalid = 1'b1;
      if (w_lag > 0 && !aw_pend && w_pend) begin
        chk("awready while W pending", 64'(s_axi_awready), 64'(0));
        chk("bvalid while W pending", 64'(s_axi_bvalid), 64'(0));
      end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("write handshake in time", 64'({aw_pend, w_pend}), 64'(0));
    cyc = 0;
    while (!s_axi_bvalid && cyc < 10) begin @(negedge aclk); cyc++; end
    chk("bvalid latency", 64'(cyc), 64'(1));
    resp = s_axi_bresp;
    for (int i = 0; i < b_lag; i++) begin
      @(negedge aclk);
      chk("bvalid/bresp held", 64'({s_axi_bvalid, s_axi_bresp}), 64'({1'b1, resp}));
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    chk("bvalid cleared, readies back", 64'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 64'(3'b011));
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_lag,
                          output logic [31:0] data, output logic [1:0] resp);
    bit fire;
    int cyc;
    cyc = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    do begin
      fire = s_axi_arready;
      @(negedge aclk); cyc++;
    end while (!fire && cyc < 20);
    s_axi_arvalid = 1'b0;
    chk("rvalid one cycle after AR", 64'(s_axi_rvalid), 64'(1));
    data = s_axi_rdata; resp = s_axi_rresp;
    for (int i = 0; i < r_lag; i++) begin
      @(negedge aclk);
      chk("rvalid/rdata held", {29'b0, s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {29'b0, 1'b1, resp, data});
    end
    s_axi_rready = 1'b1;
    @(negedge aclk);
    s_axi_rready = 1'b0;
    chk("rvalid cleared, arready back", 64'({s_axi_rvalid, s_axi_arready}), 64'(2'b01));
  endtask

  function automatic vec_t wv(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] r, input bit we, input logic [IW-1:0] idx,
                              input logic [CW-1:0] val, input bit clr, input bit en);
    vec_t v;
    v = '{1'b0, a, d, s, r, 32'h0, we, idx, val, clr, en};
    return v;
  endfunction

  function automatic vec_t rv(input logic [AW-1:0] a, input logic [31:0] rd, input logic [1:0] r,
                              input bit en);
    vec_t v;
    v = '{1'b1, a, 32'h0, 4'h0, r, rd, 1'b0, '0, '0, 1'b0, en};
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          c0;

    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("outputs in reset", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
        s_axi_rvalid, s_axi_rresp, fir_enable, fir_clear, coeff_we, coeff_addr, coeff_wdata}, 64'(0));
    chk("rdata in reset", 64'(s_axi_rdata), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    chk("readies after reset", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));

    vt.push_back(wv(10'h000, 32'h2,        4'hF, OK,  0, 0,  0,       1, 0));
    vt.push_back(rv(10'h000, 32'h0,        OK, 0));
    vt.push_back(wv(10'h000, 32'h1,        4'hF, OK,  0, 0,  0,       0, 1));
    vt.push_back(rv(10'h000, 32'h1,        OK, 1));
    vt.push_back(rv(10'h004, 32'h1,        OK, 1));
    vt.push_back(rv(10'h008, 32'd16,       OK, 1));
    vt.push_back(wv(10'h010, 32'h7FFF,     4'hF, OK,  1, 0,  16'h7FFF, 0, 1));
    vt.push_back(wv(10'h014, 32'h4000,     4'hF, OK,  1, 1,  16'h4000, 0, 1));
    vt.push_back(rv(10'h014, RB ? 32'h4000 : 32'h0, OK, 1));
    vt.push_back(wv(10'h010, 32'hFFFF8000, 4'hF, OK,  1, 0,  16'h8000, 0, 1));
    vt.push_back(rv(10'h010, RB ? 32'hFFFF8000 : 32'h0, OK, 1));
    vt.push_back(wv(10'h010, 32'h12,       4'h1, OK,  1, 0,  RB ? 16'h8012 : 16'h0012, 0, 1));
    vt.push_back(rv(10'h010, RB ? 32'hFFFF8012 : 32'h0, OK, 1));
    vt.push_back(wv(10'h050, 32'h1234,     4'hF, SLV, 0, 0,  0,       0, 1));
    vt.push_back(rv(10'h050, 32'h0,        SLV, 1));
    vt.push_back(rv(10'h3FC, 32'h0,        SLV, 1));
    vt.push_back(wv(10'h004, 32'h0,        4'hF, SLV, 0, 0,  0,       0, 1));
    vt.push_back(wv(10'h008, 32'h0,        4'hF, SLV, 0, 0,  0,       0, 1));
    vt.push_back(wv(10'h00C, 32'h3,        4'hF, SLV, 0, 0,  0,       0, 1));
    vt.push_back(rv(10'h00C, 32'h0,        SLV, 1));
    vt.push_back(wv(10'h04C, 32'hABCD,     4'h3, OK,  1, 15, 16'hABCD, 0, 1));
    vt.push_back(rv(10'h04F, RB ? 32'hFFFFABCD : 32'h0, OK, 1));
    vt.push_back(wv(10'h016, 32'h12345678, 4'h1, OK,  1, 1,  RB ? 16'h4078 : 16'h0078, 0, 1));
    vt.push_back(wv(10'h014, 32'hAAAA99BB, 4'h2, OK,  1, 1,  RB ? 16'h9978 : 16'h9900, 0, 1));
    vt.push_back(rv(10'h014, RB ? 32'hFFFF9978 : 32'h0, OK, 1));
    vt.push_back(wv(10'h000, 32'h0,        4'h0, OK,  0, 0,  0,       0, 1));
    vt.push_back(rv(10'h004, 32'h1,        OK, 1));
    vt.push_back(wv(10'h000, 32'h0,        4'hF, OK,  0, 0,  0,       0, 0));
    vt.push_back(rv(10'h000, 32'h0,        OK, 0));
    vt.push_back(wv(10'h000, 32'h3,        4'hF, OK,  0, 0,  0,       1, 1));
    vt.push_back(rv(10'h000, 32'h1,        OK, 1));

    foreach (vt[i]) begin
      if (vt[i].rd) begin
        axi_read(vt[i].addr, i % 3, rd, rs);
        chk($sformatf("v%0d rdata", i), 64'(rd), 64'(vt[i].rdata));
        chk($sformatf("v%0d rresp", i), 64'(rs), 64'(vt[i].resp));
      end else begin
        c0 = clr_cnt;
        if (vt[i].we) exp_q.push_back('{vt[i].idx, vt[i].val});
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, i % 2, rs);
        chk($sformatf("v%0d bresp", i), 64'(rs), 64'(vt[i].resp));
        chk($sformatf("v%0d fir_clear pulses", i), 64'(clr_cnt - c0), 64'(vt[i].clr));
      end
      chk($sformatf("v%0d fir_enable", i), 64'(fir_enable), 64'(vt[i].en));
    end

    // AW three cycles ahead of W, response stalled five cycles
    exp_q.push_back('{4'd2, 16'h0BAD});
    axi_write(10'h018, 32'h0BAD, 4'hF, 3, 5, rs);
    chk("late-W bresp", 64'(rs), 64'(OK));
    repeat (4) @(negedge aclk);
    chk("late-W single commit", 64'(exp_q.size()), 64'(0));

    // Read of a coefficient in the same cycle as its commit sees the old value
    exp_q.push_back('{4'd3, 16'h1111});
    axi_write(10'h01C, 32'h1111, 4'hF, 0, 0, rs);
    exp_q.push_back('{4'd3, 16'h2222});
    s_axi_awaddr = 10'h01C; s_axi_wdata = 32'h2222; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 10'h01C; s_axi_arvalid = 1'b1;
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    chk("collide rvalid+bvalid", 64'({s_axi_rvalid, s_axi_bvalid}), 64'(2'b11));
    chk("collide read old value", 64'(s_axi_rdata), RB ? 64'h1111 : 64'h0);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    axi_read(10'h01C, 0, rd, rs);
    chk("collide read new value", 64'(rd), RB ? 64'h2222 : 64'h0);

    // Reset while both bvalid and rvalid are pending
    s_axi_awaddr = 10'h008; s_axi_wdata = 32'h0; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 10'h000; s_axi_arvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge aclk);
    chk("pre-reset bvalid+rvalid", 64'({s_axi_bvalid, s_axi_rvalid, fir_enable}), 64'(3'b111));
    #1 aresetn = 1'b0;
    #1 chk("reset drops valids/enable", 64'({s_axi_bvalid, s_axi_rvalid, fir_enable}), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("readies after mid reset", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));

    // Reset in the commit cycle discards the latched write
    c0 = clr_cnt;
    s_axi_awaddr = 10'h000; s_axi_wdata = 32'h3; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    #1 aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("discarded write: no bvalid/enable/clear", 64'({s_axi_bvalid, fir_enable, 30'(clr_cnt - c0)}), 64'(0));

    // A lone W after reset must wait for a fresh AW
    s_axi_wdata = 32'h5555; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("lone W no response", 64'({s_axi_bvalid, s_axi_wready, s_axi_awready}), 64'(3'b001));
    exp_q.push_back('{4'd5, 16'h5555});
    s_axi_awaddr = 10'h024; s_axi_awvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    @(negedge aclk);
    chk("late AW commit", 64'({s_axi_bvalid, s_axi_bresp}), 64'({1'b1, OK}));
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    axi_read(10'h01C, 1, rd, rs);
    chk("shadow cleared by reset", 64'({rs, rd}), 64'(0));
    axi_read(10'h024, 0, rd, rs);
    chk("post-reset coeff readback", 64'(rd), RB ? 64'h5555 : 64'h0);

    repeat (3) @(negedge aclk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
